pipelined_barrel_shifter: RTL and testbench

PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

---
 rtl/bshift_pkg.sv | 16 +
 rtl/bshift_stage.sv | 106 ++++++++++
 rtl/pipelined_barrel_shifter.sv | 80 ++++++++
 tb/tb_pipelined_barrel_shifter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bshift_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings.
// Codes 101..111 are all treated as pass-through; BS_PASS is the canonical one.

package bshift_pkg;

    typedef enum logic [2:0] {
        BS_LSL = 3'b000,
        BS_LSR = 3'b001,
        BS_ASR = 3'b010,
        BS_ROR = 3'b011,
        BS_ROL = 3'b100
    } bs_mode_e;

    localparam logic [2:0] BS_PASS = 3'b101;

endpackage

// File: rtl/bshift_stage.sv
// One pipeline stage of the barrel shifter: a single mux layer that shifts by
// 2^K when ctrl bit K is set, followed by the stage registers.
// With BSHIFT_FLAGS_EN defined, stage 0 also derives the carry flag from the
// original operand and every stage carries it forward next to the data.

module bshift_stage
    import bshift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int K     = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       src_valid,
    input  logic [WIDTH-1:0]           src_data,
    input  logic [2:0]                 src_mode,
    input  logic [$clog2(WIDTH)-1:0]   src_ctrl,
`ifdef BSHIFT_FLAGS_EN
    input  logic                       src_carry,
    output logic                       carry,
`endif
    output logic                       valid,
    output logic [WIDTH-1:0]           data,
    output logic [2:0]                 mode,
    output logic [$clog2(WIDTH)-1:0]   ctrl
);

    localparam int SHW = $clog2(WIDTH);
    localparam int S   = 1 << K;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] next_data;

    // Shift the incoming word by this stage's fixed amount according to mode
    always_comb begin
        shifted = src_data;
        case (src_mode)
            BS_LSL:  shifted = src_data << S;
            BS_LSR:  shifted = src_data >> S;
            BS_ASR:  shifted = $signed(src_data) >>> S;
            BS_ROR:  shifted = (src_data >> S) | (src_data << (WIDTH - S));
            BS_ROL:  shifted = (src_data << S) | (src_data >> (WIDTH - S));
            default: shifted = src_data;
        endcase
    end

    assign next_data = src_ctrl[K] ? shifted : src_data;

`ifdef BSHIFT_FLAGS_EN
    logic carry_start;
    logic carry_next;

    if (K == 0) begin : g_carry
        logic [SHW-1:0] left_idx;
        logic [SHW-1:0] right_idx;

        // Index of the last bit to leave the word: WIDTH-ctrl going left, ctrl-1 going right
        assign left_idx  = '0 - src_ctrl;
        assign right_idx = src_ctrl - SHW'(1);

        // Pick the final bit shifted or rotated out; nothing leaves on a zero shift or pass-through
        always_comb begin
            carry_start = 1'b0;
            if (src_ctrl != '0) begin
                case (src_mode)
                    BS_LSL, BS_ROL:         carry_start = src_data[left_idx];
                    BS_LSR, BS_ASR, BS_ROR: carry_start = src_data[right_idx];
                    default:                carry_start = 1'b0;
                endcase
            end
        end
    end else begin : g_no_carry
        assign carry_start = 1'b0;
    end

    assign carry_next = src_carry | carry_start;

    // Carry register advances only with a real word so it stays aligned with data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry <= 1'b0;
        end else if (en && src_valid) begin
            carry <= carry_next;
        end
    end
`endif

    // Valid bit moves every unstalled cycle; payload registers load only with a real word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            mode  <= '0;
            ctrl  <= '0;
        end else if (en) begin
            valid <= src_valid;
            if (src_valid) begin
                data <= next_data;
                mode <= src_mode;
                ctrl <= src_ctrl;
            end
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: SHW = log2(WIDTH) registered stages, stage k
// applies a shift of 2^k. The whole pipe stalls together when the result is
// waiting and the consumer is not ready.
// Optional flag outputs (carry, zero) are built when BSHIFT_FLAGS_EN is defined.

module pipelined_barrel_shifter
    import bshift_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   ctrl,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
`ifdef BSHIFT_FLAGS_EN
    ,
    output logic             carry,
    output logic             zero
`endif
);

    logic             stall;
    logic             valid_s [0:SHW];
    logic [WIDTH-1:0] data_s  [0:SHW];
    logic [2:0]       mode_s  [0:SHW];
    logic [SHW-1:0]   ctrl_s  [0:SHW];
`ifdef BSHIFT_FLAGS_EN
    logic             carry_s [0:SHW];
`endif

    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;

    assign valid_s[0] = in_valid;
    assign data_s[0]  = in;
    assign mode_s[0]  = mode;
    assign ctrl_s[0]  = ctrl;
`ifdef BSHIFT_FLAGS_EN
    assign carry_s[0] = 1'b0;
`endif

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        bshift_stage #(
            .WIDTH (WIDTH),
            .K     (k)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (~stall),
            .src_valid (valid_s[k]),
            .src_data  (data_s[k]),
            .src_mode  (mode_s[k]),
            .src_ctrl  (ctrl_s[k]),
`ifdef BSHIFT_FLAGS_EN
            .src_carry (carry_s[k]),
            .carry     (carry_s[k+1]),
`endif
            .valid     (valid_s[k+1]),
            .data      (data_s[k+1]),
            .mode      (mode_s[k+1]),
            .ctrl      (ctrl_s[k+1])
        );
    end

    assign out_valid = valid_s[SHW];
    assign out       = data_s[SHW];

`ifdef BSHIFT_FLAGS_EN
    assign carry = carry_s[SHW];
    assign zero  = (data_s[SHW] == '0);
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter at WIDTH=8 (three stages).
// A queue-based reference model tracks every accepted word and its age in the
// pipe; results come from plain double-width shift arithmetic.
// Flag checks are compiled in when BSHIFT_FLAGS_EN is defined.

module tb_pipelined_barrel_shifter;

    localparam int W   = 8;
    localparam int SHW = 3;

    typedef struct {
        logic [W-1:0] data;
        logic         carry;
        int           age;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in = '0;
    logic [SHW-1:0] ctrl = '0;
    logic [2:0]     mode = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W-1:0]   out;
`ifdef BSHIFT_FLAGS_EN
    logic           carry;
    logic           zero;
`endif

    exp_t q[$];
    int   checksTotal  = 0;
    int   checksPassed = 0;

    pipelined_barrel_shifter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in),
        .ctrl      (ctrl),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
`ifdef BSHIFT_FLAGS_EN
        ,
        .carry     (carry),
        .zero      (zero)
`endif
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    // Reference result for one operation, from the arithmetic definition of each mode
    function automatic exp_t refModel(input logic [W-1:0] a, input int sh, input logic [2:0] md);
        exp_t             r;
        logic [2*W-1:0]   dbl;
        logic [3*W-1:0]   wide3;
        r.age   = 1;
        r.data  = a;
        r.carry = 1'b0;
        case (md)
            3'b000: begin
                dbl     = {{W{1'b0}}, a} << sh;
                r.data  = dbl[W-1:0];
                r.carry = dbl[W];
            end
            3'b001: begin
                dbl     = {a, {W{1'b0}}} >> sh;
                r.data  = dbl[2*W-1:W];
                r.carry = dbl[W-1];
            end
            3'b010: begin
                wide3   = {{W{a[W-1]}}, a, {W{1'b0}}} >> sh;
                r.data  = wide3[2*W-1:W];
                r.carry = wide3[W-1];
            end
            3'b011: begin
                dbl     = {a, a} >> sh;
                r.data  = dbl[W-1:0];
                r.carry = (sh != 0) ? r.data[W-1] : 1'b0;
            end
            3'b100: begin
                dbl     = {a, a} << sh;
                r.data  = dbl[2*W-1:W];
                r.carry = (sh != 0) ? r.data[0] : 1'b0;
            end
            default: begin
                r.data  = a;
                r.carry = 1'b0;
            end
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checksTotal++;
        assert (got === exp) checksPassed++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic modelValid();
        return (q.size() > 0) && (q[0].age == SHW);
    endfunction

    // Compare DUT outputs against the model for the current cycle
    task automatic checkOutput(input string tag);
        logic expValid;
        expValid = modelValid();
        check({tag, ".out_valid"}, 64'(out_valid), 64'(expValid));
        check({tag, ".in_ready"}, 64'(in_ready), 64'(!(expValid && !out_ready)));
        if (expValid) begin
            check({tag, ".out"}, 64'(out), 64'(q[0].data));
`ifdef BSHIFT_FLAGS_EN
            check({tag, ".carry"}, 64'(carry), 64'(q[0].carry));
            check({tag, ".zero"}, 64'(zero), 64'(q[0].data == '0));
`endif
        end
    endtask

    // Drive one cycle of inputs, check, clock, and advance the model
    task automatic applyStimulus(input string tag, input logic v, input logic [W-1:0] d,
                                 input logic [SHW-1:0] c, input logic [2:0] m, input logic ordy);
        logic expValid;
        logic stall;
        logic acc;
        logic pop;
        exp_t e;
        in_valid  = v;
        in        = d;
        ctrl      = c;
        mode      = m;
        out_ready = ordy;
        #1;
        checkOutput(tag);
        expValid = modelValid();
        stall    = expValid && !ordy;
        acc      = v && !stall;
        pop      = expValid && ordy;
        e        = refModel(d, int'(c), m);
        @(posedge clk);
        #1;
        if (!stall) begin
            if (pop) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (acc) q.push_back(e);
        end
    endtask

    // Issue one word, wait the pipeline latency, then check against fixed values
    task automatic directed(input string tag, input logic [W-1:0] d, input logic [SHW-1:0] c,
                            input logic [2:0] m, input logic [W-1:0] expOut, input logic expCarry);
        applyStimulus(tag, 1'b1, d, c, m, 1'b1);
        repeat (SHW - 1) applyStimulus(tag, 1'b0, '0, '0, '0, 1'b1);
        check({tag, ".lat_valid"}, 64'(out_valid), 64'(1));
        check({tag, ".const_out"}, 64'(out), 64'(expOut));
`ifdef BSHIFT_FLAGS_EN
        check({tag, ".const_carry"}, 64'(carry), 64'(expCarry));
        check({tag, ".const_zero"}, 64'(zero), 64'(expOut == '0));
`else
        if (expCarry) begin end
`endif
        applyStimulus({tag, ".drain"}, 1'b0, '0, '0, '0, 1'b1);
    endtask

    initial begin
        $display("[TB] start");

        // Reset state, sampled while reset is held
        #2;
        check("reset.out_valid", 64'(out_valid), 64'(0));
        check("reset.out", 64'(out), 64'(0));
        check("reset.in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus("post_reset", 1'b0, '0, '0, '0, 1'b1);

        // Directed operations
        directed("lsl1", 8'b00011001, 3'd1, 3'b000, 8'b00110010, 1'b0);
        directed("asr3", 8'b10011001, 3'd3, 3'b010, 8'b11110011, 1'b0);
        directed("rol3", 8'b10011001, 3'd3, 3'b100, 8'b11001100, 1'b0);
        directed("ror4", 8'b10011001, 3'd4, 3'b011, 8'b10011001, 1'b1);
        directed("lsl7", 8'b11110000, 3'd7, 3'b000, 8'b00000000, 1'b0);
        directed("ctrl0", 8'hA5, 3'd0, 3'b010, 8'hA5, 1'b0);
        directed("pass", 8'h3C, 3'd5, 3'b110, 8'h3C, 1'b0);

        // Back-to-back burst of five words
        for (int i = 0; i < 5; i++)
            applyStimulus("burst", 1'b1, 8'(8'h11 * (i + 1)), 3'(i + 1), 3'(i), 1'b1);
        repeat (6) applyStimulus("burst_drain", 1'b0, '0, '0, '0, 1'b1);

        // Fill the pipe, then hold the consumer off for four cycles
        for (int i = 0; i < 4; i++)
            applyStimulus("fill", 1'b1, 8'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 4)), 1'b1);
        repeat (4) applyStimulus("stall", 1'b1, 8'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 4)), 1'b0);
        repeat (8) applyStimulus("release", 1'b0, '0, '0, '0, 1'b1);

        // Randomised traffic with random back-pressure
        for (int i = 0; i < 200; i++)
            applyStimulus("rand", 1'(($urandom % 10) < 7), 8'($urandom),
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                          1'(($urandom % 4) != 0));
        repeat (12) applyStimulus("rand_drain", 1'b0, '0, '0, '0, 1'b1);

        // Reset with two words in flight: nothing may emerge afterwards
        applyStimulus("mid_a", 1'b1, 8'h5A, 3'd2, 3'b000, 1'b1);
        applyStimulus("mid_b", 1'b1, 8'hC3, 3'd1, 3'b001, 1'b1);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midreset.out_valid", 64'(out_valid), 64'(0));
        check("midreset.out", 64'(out), 64'(0));
        check("midreset.in_ready", 64'(in_ready), 64'(1));
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (6) applyStimulus("after_reset", 1'b0, '0, '0, '0, 1'b1);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
